// File: rtl/imem_pkg.sv
// Shared encodings for the instruction-memory responder.
// Addresses and data words are MSB-first: bit 0 is the most significant bit.
package imem_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [0:31] ERR_WORD   = 32'h0000_0000;

    function automatic logic misaligned(input logic [0:31] addr);
        return addr[30:31] != 2'b00;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side instruction interface: request/response valid-ready pairs plus a redirect flush.
interface imem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [0:31] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:31] rsp_instr;
    logic [0:31] rsp_addr;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

endinterface

// File: rtl/imem_byte_array.sv
// Byte-wide backing store with a combinational big-endian 4-byte read port.
// Out-of-range addresses read from index 0 so the array is never indexed past its end.
module imem_byte_array
    import imem_pkg::*;
#(
    parameter int unsigned SIZE = 4096
) (
    input  logic [0:31] phys,
    output logic [0:31] word,
    output logic        range_ok
);

    localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [0:7]    mem [0:SIZE-1];
    logic [AW-1:0] base;

    always_comb begin
        range_ok = phys <= 32'(SIZE - WORD_BYTES);
        base     = range_ok ? phys[32-AW:31] : '0;
        word     = {mem[base], mem[base + AW'(1)], mem[base + AW'(2)], mem[base + AW'(3)]};
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, response after a fixed LATENCY,
// held until consumed; flush drops whatever is in flight.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned SIZE    = 4096,
    parameter logic [0:31] OFFSET  = 32'h0,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    imem_responder_if.slave bus
);

    localparam int unsigned CNT_W = 4;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:31]      addr_q, addr_d;
    logic [0:31]      rsp_instr_q, rsp_instr_d;
    logic [0:31]      rsp_addr_q, rsp_addr_d;
    logic             rsp_err_q, rsp_err_d;

    logic [0:31] look_addr, phys, word;
    logic        range_ok, look_err, accept, load;

    // With LATENCY==1 the response is formed on the accept edge, so look up the live address in IDLE.
    assign look_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
    assign phys      = look_addr - OFFSET;
    assign look_err  = misaligned(look_addr) | ~range_ok;

    imem_byte_array #(.SIZE(SIZE)) u_mem (
        .phys     (phys),
        .word     (word),
        .range_ok (range_ok)
    );

    assign bus.req_ready = rst & (state_q == IDLE) & ~bus.flush;
    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_instr_d = rsp_instr_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;
        load        = 1'b0;

        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_d = bus.req_addr;
                        cnt_d  = CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_d = RESP;
                            load    = 1'b1;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESP;
                        load    = 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            rsp_instr_d = look_err ? ERR_WORD : word;
            rsp_addr_d  = look_addr;
            rsp_err_d   = look_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_instr_q <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
